disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan scheduler for the 4-digit seven-segment display on the alarm clock board.
- Generates the digit-select code and 4-bit digit value consumed by the seven-segment decoder/anode driver.
- Holds a frame-atomic shadow copy of the digits and display config, loaded by request/acknowledge handshake from the timekeeping/alarm-set logic.
- Provides blink (time-set mode), leading-zero suppression and decimal-point scheduling.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- BLINK_FRAMES, 125, full 4-digit frames per blink half-period (0.5 s at defaults); must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  16  digit values: [3:0]=digit0 (rightmost) … [15:12]=digit3.
- blink_en_in  in  1  blink enable.
- blink_mask_in  in  4  per-digit blink select, bit i = digit i.
- dp_mask_in  in  4  per-digit decimal point enable.
- lz_sup_in  in  1  suppress digit3 when its value is 0.
- upd_req  in  1  request to load shadow from *_in; level, held until upd_ack.
- upd_ack  out  1  one-cycle pulse when shadow loaded.
- sel  out  2  active digit index, drives decoder enable.
- num  out  4  value of active digit.
- blank  out  1  1 = active digit must be dark.
- dp  out  1  decimal point for active digit, active high.
- frame_done  out  1  one-cycle pulse at end of each 4-digit frame.

Behaviour:
- Reset (async assert, sync-safe deassert): div count=0, sel=0, shadow digits/masks/flags=0, blink frame count=0, blink_phase=0, upd_ack=0, frame_done=0. Resulting outputs: num=0, blank=0, dp=0.
- Divider: cnt runs 0..REFRESH_DIV-1 and wraps to 0. tick=1 on the cycle cnt==REFRESH_DIV-1.
- Scan: on tick, sel <= sel+1 mod 4 (0→1→2→3→0). The scan never stalls.
- Frame boundary (fb) = tick while sel==3. On fb, frame_done=1 for exactly that next cycle (registered).
- Update handshake:
  - On fb with upd_req=1, the shadow loads all *_in values sampled that cycle, and upd_ack pulses 1 cycle later, coincident with sel=0.
  - upd_req=0 at fb: no load.
  - Requester holds *_in stable and upd_req high until upd_ack. It drops upd_req the cycle after ack.
  - If upd_req is still high at a later fb, another load and ack occur. This is legal and idempotent.
  - *_in changes while no request is pending have no effect on outputs.
- Blink:
  - When shadow blink_en=0: blink frame count=0 and blink_phase=0.
  - Otherwise, on each fb, the count increments. When it reaches BLINK_FRAMES-1 and fb occurs, the count wraps to 0 and blink_phase toggles.
  - A shadow load that sets blink_en from 0 to 1 starts the count at 0 with phase=0 (visible first).
- Output functions, all from registered state only (no input-to-output combinational path):
  - num = shadow digit[sel].
  - blank = (blink_en & blink_mask[sel] & blink_phase) | (lz_sup & sel==3 & digit3==0).
  - dp = dp_mask[sel] & ~blank.
- Values 10–15 pass through unmodified. Decoding is the downstream decoder's job.
- Simultaneous events: fb + upd_req + blink wrap in one cycle. The shadow load and the blink update take effect together. The new blink_en governs; if it is 0, the phase is forced to 0.
- Reset mid-frame or mid-handshake: all state clears, no ack is issued, and the requester re-requests.
- Counter widths: $clog2(REFRESH_DIV) and $clog2(BLINK_FRAMES+1). No overflow is permitted.

Test Plan:
Benches use REFRESH_DIV=4 and BLINK_FRAMES=2.
- Reset release, idle 40 cycles -> sel steps 0,1,2,3,0 every 4 cycles; num=0, blank=0, dp=0; frame_done pulses every 16 cycles, aligned with sel returning to 0.
- Update: upd_req=1, digits_in=16'h1234, dp_mask=4'b0100 mid-frame -> no output change until fb; then upd_ack pulses once; num sequence 4,3,2,1 for sel 0..3; dp=1 only at sel=2.
- Leading zero: load digits 16'h0930, lz_sup=1 -> blank=1 only at sel=3; reload with lz_sup=0 -> digit3 shows num=0 with blank=0.
- Blink: load blink_en=1, blink_mask=4'b0011 -> digits 0,1 visible for 2 frames, blanked for 2 frames, repeating; digits 2,3 never blank; dp suppressed while blanked.
- Collision: upd_req held high across a blink-phase wrap at fb, loading blink_en=0 -> blank=0 from the next cycle; phase and count read 0.
- Async reset mid-handshake: assert rst_n=0 between fb and ack, asynchronous to clk -> outputs clear immediately; no upd_ack after release; shadow=0.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Scan scheduler for a 4-digit seven-segment display: steps the digit select,
// serves a frame-atomic shadow of digits/config, and applies blink, LZ and DP.
module disp_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        blink_en_in,
  input  logic [3:0]  blink_mask_in,
  input  logic [3:0]  dp_mask_in,
  input  logic        lz_sup_in,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [1:0]  sel,
  output logic [3:0]  num,
  output logic        blank,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [15:0]   r_digits;
  logic          r_blink_en;
  logic [3:0]    r_blink_mask;
  logic [3:0]    r_dp_mask;
  logic          r_lz_sup;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          r_upd_ack;
  logic          r_frame_done;

  logic w_tick;
  logic w_fb;
  logic w_load;
  logic w_blink_en_nxt;
  logic w_blink_restart;
  logic w_blank;

  assign w_tick          = (r_cnt == CNT_LAST);
  assign w_fb            = w_tick & (r_sel == 2'd3);
  assign w_load          = w_fb & upd_req;
  // The blink_en that will be in the shadow after this edge decides the blink state.
  assign w_blink_en_nxt  = w_load ? blink_en_in : r_blink_en;
  assign w_blink_restart = ~w_blink_en_nxt | (w_load & ~r_blink_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_sel         <= 2'd0;
      r_digits      <= 16'd0;
      r_blink_en    <= 1'b0;
      r_blink_mask  <= 4'd0;
      r_dp_mask     <= 4'd0;
      r_lz_sup      <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_upd_ack     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
      r_frame_done <= w_fb;
      r_upd_ack    <= w_load;
      if (w_tick) begin
        r_sel <= r_sel + 2'd1;
      end
      if (w_load) begin
        r_digits     <= digits_in;
        r_blink_en   <= blink_en_in;
        r_blink_mask <= blink_mask_in;
        r_dp_mask    <= dp_mask_in;
        r_lz_sup     <= lz_sup_in;
      end
      if (w_blink_restart) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (w_fb) begin
        if (r_blink_cnt == BLK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  assign w_blank = (r_blink_en & r_blink_mask[r_sel] & r_blink_phase) |
                   (r_lz_sup & (r_sel == 2'd3) & (r_digits[15:12] == 4'd0));

  assign upd_ack    = r_upd_ack;
  assign frame_done = r_frame_done;
  assign sel        = r_sel;
  assign num        = r_digits[{r_sel, 2'b00} +: 4];
  assign blank      = w_blank;
  assign dp         = r_dp_mask[r_sel] & ~w_blank;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = 16'd0;
  logic        blink_en_in = 1'b0;
  logic [3:0]  blink_mask_in = 4'd0;
  logic [3:0]  dp_mask_in = 4'd0;
  logic        lz_sup_in = 1'b0;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic [1:0]  sel;
  logic [3:0]  num;
  logic        blank;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  disp_scan_ctrl #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blink_en_in(blink_en_in),
    .blink_mask_in(blink_mask_in), .dp_mask_in(dp_mask_in), .lz_sup_in(lz_sup_in),
    .upd_req(upd_req), .upd_ack(upd_ack), .sel(sel), .num(num), .blank(blank),
    .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t required=finish_before_limit", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin step(); n++; end while (frame_done !== 1'b1 && n < 40);
    total++;
    if (frame_done !== 1'b1) begin
      bad++; $display("FAIL frame_wait frame_done=%b required=1", frame_done);
    end
  endtask

  // Returns on the ack cycle, which is the first cycle of the new frame (sel=0).
  task automatic do_load(input logic [15:0] d, input logic be, input logic [3:0] bm,
                         input logic [3:0] dm, input logic lz);
    int n = 0;
    digits_in = d; blink_en_in = be; blink_mask_in = bm; dp_mask_in = dm; lz_sup_in = lz;
    upd_req = 1'b1;
    do begin step(); n++; end while (upd_ack !== 1'b1 && n < 40);
    total++;
    if (upd_ack !== 1'b1 || sel !== 2'd0 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL load_ack ack=%b sel=%0d fd=%b required ack=1 sel=0 fd=1", upd_ack, sel, frame_done);
    end
    upd_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({sel, num, blank, dp, upd_ack, frame_done} !== 10'd0) begin
      bad++;
      $display("FAIL reset_out sel=%0d num=%h blank=%b dp=%b ack=%b fd=%b required all 0",
               sel, num, blank, dp, upd_ack, frame_done);
    end
    #10 rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      logic [1:0] es;
      logic       efd;
      step();
      es  = 2'((k / 4) % 4);
      efd = (k % 16 == 0);
      total++;
      if (sel !== es || frame_done !== efd || num !== 4'd0 || blank !== 1'b0 || dp !== 1'b0) begin
        bad++;
        $display("FAIL idle_scan k=%0d sel=%0d fd=%b num=%h blank=%b dp=%b required sel=%0d fd=%b num=0 blank=0 dp=0",
                 k, sel, frame_done, num, blank, dp, es, efd);
      end
    end
  endtask

  task automatic test_update();
    logic [15:0] d = 16'h1234;
    int n = 0;
    digits_in = 16'hFFFF; dp_mask_in = 4'hF; lz_sup_in = 1'b1; blink_en_in = 1'b1;
    blink_mask_in = 4'hF; upd_req = 1'b0;
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (num !== 4'd0 || dp !== 1'b0 || blank !== 1'b0) begin
        bad++;
        $display("FAIL no_req_ignore k=%0d num=%h dp=%b blank=%b required 0 0 0", k, num, dp, blank);
      end
      step();
    end
    for (int k = 0; k < 5; k++) step();
    digits_in = d; dp_mask_in = 4'b0100; lz_sup_in = 1'b0; blink_en_in = 1'b0;
    blink_mask_in = 4'd0; upd_req = 1'b1;
    step();
    while (upd_ack !== 1'b1 && n < 40) begin
      total++;
      if (num !== 4'd0 || dp !== 1'b0) begin
        bad++; $display("FAIL pre_fb_hold n=%0d num=%h dp=%b required num=0 dp=0", n, num, dp);
      end
      step(); n++;
    end
    total++;
    if (upd_ack !== 1'b1 || sel !== 2'd0) begin
      bad++; $display("FAIL upd_ack ack=%b sel=%0d required ack=1 sel=0", upd_ack, sel);
    end
    upd_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      int s = k / 4;
      total++;
      if (sel !== 2'(s) || num !== d[s*4 +: 4] || dp !== (s == 2) || blank !== 1'b0 ||
          (k > 0 && upd_ack !== 1'b0)) begin
        bad++;
        $display("FAIL update_scan k=%0d sel=%0d num=%h dp=%b blank=%b ack=%b required sel=%0d num=%h dp=%b blank=0",
                 k, sel, num, dp, blank, upd_ack, s, d[s*4 +: 4], (s == 2));
      end
      step();
    end
    total++;
    if (upd_ack !== 1'b0) begin
      bad++; $display("FAIL ack_single ack=%b required 0", upd_ack);
    end
  endtask

  task automatic test_lz();
    logic [15:0] d = 16'h0930;
    do_load(d, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      int s = k / 4;
      total++;
      if (num !== d[s*4 +: 4] || blank !== (s == 3) || dp !== 1'b0) begin
        bad++;
        $display("FAIL lz_on k=%0d num=%h blank=%b dp=%b required num=%h blank=%b dp=0",
                 k, num, blank, dp, d[s*4 +: 4], (s == 3));
      end
      step();
    end
    do_load(d, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      int s = k / 4;
      total++;
      if (num !== d[s*4 +: 4] || blank !== 1'b0) begin
        bad++;
        $display("FAIL lz_off k=%0d num=%h blank=%b required num=%h blank=0", k, num, blank, d[s*4 +: 4]);
      end
      step();
    end
  endtask

  task automatic test_blink();
    logic [15:0] d = 16'h5678;
    logic [3:0]  bm = 4'b0011;
    do_load(d, 1'b1, bm, 4'hF, 1'b0);
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 16; k++) begin
        int   s = k / 4;
        logic eb;
        eb = ((f / 2) % 2 == 1) && bm[s];
        total++;
        if (num !== d[s*4 +: 4] || blank !== eb || dp !== ~eb) begin
          bad++;
          $display("FAIL blink f=%0d k=%0d num=%h blank=%b dp=%b required num=%h blank=%b dp=%b",
                   f, k, num, blank, dp, d[s*4 +: 4], eb, ~eb);
        end
        step();
      end
    end
  endtask

  task automatic test_collision();
    do_load(16'h5678, 1'b0, 4'b0011, 4'hF, 1'b0);
    do_load(16'h5678, 1'b1, 4'b0011, 4'hF, 1'b0);
    wait_frame();
    // The coming frame boundary would toggle the phase; the load of blink_en=0 wins.
    do_load(16'h5678, 1'b0, 4'b0011, 4'hF, 1'b0);
    total++;
    if (dut.r_blink_phase !== 1'b0 || dut.r_blink_cnt !== '0) begin
      bad++;
      $display("FAIL collision_state phase=%b cnt=%0d required phase=0 cnt=0",
               dut.r_blink_phase, dut.r_blink_cnt);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (blank !== 1'b0 || dp !== 1'b1) begin
        bad++; $display("FAIL collision_scan k=%0d blank=%b dp=%b required blank=0 dp=1", k, blank, dp);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    digits_in = 16'hABCD; blink_en_in = 1'b0; blink_mask_in = 4'd0; dp_mask_in = 4'd0;
    lz_sup_in = 1'b0; upd_req = 1'b1;
    while (sel !== 2'd3 && n < 20) begin step(); n++; end
    for (int k = 0; k < 3; k++) step();
    total++;
    if (sel !== 2'd3 || num !== 4'h5) begin
      bad++; $display("FAIL pre_reset sel=%0d num=%h required sel=3 num=5", sel, num);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, num, blank, dp, upd_ack, frame_done} !== 10'd0 || dut.r_digits !== 16'd0) begin
      bad++;
      $display("FAIL async_clear sel=%0d num=%h blank=%b dp=%b ack=%b fd=%b shadow=%h required all 0",
               sel, num, blank, dp, upd_ack, frame_done, dut.r_digits);
    end
    upd_req = 1'b0;
    step(); step();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      total++;
      if (upd_ack !== 1'b0 || num !== 4'd0) begin
        bad++; $display("FAIL post_reset k=%0d ack=%b num=%h required ack=0 num=0", k, upd_ack, num);
      end
    end
    do_load(16'hABCD, 1'b0, 4'd0, 4'd0, 1'b0);
    total++;
    if (num !== 4'hD) begin
      bad++; $display("FAIL rerequest num=%h required d", num);
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_lz();
    test_blink();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
